fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage of the FETCH/EX/WB RV32 pipeline, directly upstream of the EX-stage control unit. It owns the PC and drives a synchronous instruction ROM. It presents instruction_EX, pc_EX and pc_plus4_EX to EX, and consumes the control unit's stall_FETCH/pcsrc plus the EX branch-compare result. It produces stall_EX, which squashes the wrong-path instruction after every control-flow redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetched instruction after reset
IMEM_AW, 12, instruction ROM word-address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
hold  in  1  freeze entire stage (external wait)
stall_FETCH  in  1  redirect request from control unit (EX)
pcsrc  in  2  00 seq, 01 branch, 10 jal, 11 jalr
branch_taken  in  1  EX compare result, qualifies pcsrc=01
rs1_data_EX  in  32  rs1 operand for jalr target
imem_addr  out  IMEM_AW  ROM word address = pc_F[IMEM_AW+1:2]
imem_rdata  in  32  ROM data, valid one cycle after imem_addr
instruction_EX  out  32  instruction in EX (NOP 32'h0000_0013 when squashed)
pc_EX  out  32  PC of instruction_EX
pc_plus4_EX  out  32  pc_EX+4, link value for jal/jalr (regsel=11)
stall_EX  out  1  EX instruction is a bubble; EX must not write state
fetch_fault  out  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Registers: pc_F, pc_EX, state, hold_buf, hold_valid, fault.
- Reset (async): pc_F=pc_EX=RESET_PC, state=BOOT, hold_valid=0, hold_buf=NOP, fault=0. Outputs during reset: stall_EX=1, instruction_EX=NOP, pc_plus4_EX=RESET_PC+4, fetch_fault=0.
- States:
  - BOOT: ROM output not yet valid.
  - RUN: normal fetch.
  - SQUASH: wrong-path instruction in EX.
  - FAULT: only with ALIGN_CHECK_EN.
- In BOOT/SQUASH/FAULT: stall_EX=1, instruction_EX=NOP, stall_FETCH ignored.
- In RUN: stall_EX=0, instruction_EX = hold_valid ? hold_buf : imem_rdata.
- Priority: rst > hold > redirect > sequential.
- Sequential (RUN or BOOT or SQUASH, hold=0, no redirect): pc_EX<=pc_F, pc_F<=pc_F+4. Next state is RUN (FAULT stays FAULT).
- Redirect (RUN, hold=0, stall_FETCH=1): pc_F<=target, pc_EX<=pc_F, state<=SQUASH. Targets:
  - pcsrc=01 and taken: pc_EX+immB
  - pcsrc=01 and not taken: pc_EX+4
  - pcsrc=10: pc_EX+immJ
  - pcsrc=11: (rs1_data_EX+immI) & ~1
  - pcsrc=00: pc_EX+4
- Immediates are sign-extended and decoded internally from instruction_EX.
- Redirect penalty: exactly one bubble cycle; the target instruction appears in EX two cycles after the redirect cycle.
- Hold:
  - pc_F, pc_EX and state are frozen; imem_addr stays constant.
  - On the first hold cycle, imem_rdata is captured into hold_buf and hold_valid<=1.
  - hold_valid clears on the first edge with hold=0.
  - No instruction is skipped or duplicated across a hold.
- Arithmetic is 32-bit modulo; PC wraps from 0xFFFF_FFFC to 0. pc_F bits above IMEM_AW+1 are ignored by the ROM.
- Reset mid-SQUASH or mid-hold: all state is discarded, and the stage restarts in BOOT at RESET_PC.

Optional Feature:
ALIGN_CHECK_EN
- Defined: a redirect whose target[1:0]!=0 enters FAULT instead of SQUASH.
  - pc_F is not updated.
  - fetch_fault=1, sticky until rst.
  - stall_EX=1 and instruction_EX=NOP for as long as FAULT holds.
- Undefined: target[1:0] is forced to 00, FAULT is unreachable, fetch_fault is tied 0.

Test Plan:
- Boot: RESET_PC=0, ROM[0]=addi x1,x0,5. Release rst → cycle0 stall_EX=1, instr=NOP; cycle1 pc_EX=0, instr=ROM[0], stall_EX=0; cycle2 pc_EX=4.
- Taken beq at 0x10, imm=+8, stall_FETCH=1, pcsrc=01, taken=1 → next cycle stall_EX=1, instr=NOP; following cycle pc_EX=0x18, stall_EX=0.
- Not-taken branch at 0x10 (taken=0) → one bubble, then pc_EX=0x14.
- jalr at 0x20 with rs1_data_EX=0x101, imm=+4 → pc_plus4_EX=0x24 during the jalr; after the bubble pc_EX=0x104.
- hold=1 for 3 cycles while pc_EX=0x8 → pc_EX and instruction_EX stable for 3 cycles; then pc_EX=0xC, 0x10 in sequence with no gap or repeat.
- jal at 0x30 with imm=+6:
  - with ALIGN_CHECK_EN → fetch_fault=1, stall_EX stays 1 until rst.
  - without → after the bubble pc_EX=0x34, fetch_fault=0.
- Reset asserted during SQUASH → BOOT behaviour as in scenario 1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction ROM and feeds EX.
// Optional misaligned-target trap is enabled by defining ALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               stall_FETCH,
   input  logic [1:0]         pcsrc,
   input  logic               branch_taken,
   input  logic [31:0]        rs1_data_EX,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        instruction_EX,
   output logic [31:0]        pc_EX,
   output logic [31:0]        pc_plus4_EX,
   output logic               stall_EX,
   output logic               fetch_fault
);

   localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef ALIGN_CHECK_EN
   localparam logic ALIGN_CHECK = 1'b1;
`else
   localparam logic ALIGN_CHECK = 1'b0;
`endif

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      SQUASH = 2'd2,
      FAULT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] pc_ex_q, pc_ex_d;
   logic [31:0] hold_buf_q, hold_buf_d;
   logic        hold_valid_q, hold_valid_d;
   logic        fault_q, fault_d;

   logic [31:0] imm_i, imm_b, imm_j;
   logic [31:0] target_raw, target;
   logic        misaligned;

   assign imem_addr   = pc_f_q[IMEM_AW+1:2];
   assign pc_EX       = pc_ex_q;
   assign pc_plus4_EX = pc_ex_q + 32'd4;
   assign fetch_fault = fault_q;

   // Once a hold has started, the ROM output already shows the next word,
   // so the EX instruction must come from the captured copy.
   always_comb begin
      stall_EX       = 1'b1;
      instruction_EX = NOP;
      if (state_q == RUN) begin
         stall_EX       = 1'b0;
         instruction_EX = hold_valid_q ? hold_buf_q : imem_rdata;
      end
   end

   always_comb begin
      imm_i = {{20{instruction_EX[31]}}, instruction_EX[31:20]};
      imm_b = {{19{instruction_EX[31]}}, instruction_EX[31], instruction_EX[7],
               instruction_EX[30:25], instruction_EX[11:8], 1'b0};
      imm_j = {{11{instruction_EX[31]}}, instruction_EX[31], instruction_EX[19:12],
               instruction_EX[20], instruction_EX[30:21], 1'b0};
      case (pcsrc)
         2'b01:   target_raw = branch_taken ? (pc_ex_q + imm_b) : (pc_ex_q + 32'd4);
         2'b10:   target_raw = pc_ex_q + imm_j;
         2'b11:   target_raw = (rs1_data_EX + imm_i) & ~32'd1;
         default: target_raw = pc_ex_q + 32'd4;
      endcase
      misaligned = ALIGN_CHECK & (|target_raw[1:0]);
      target     = ALIGN_CHECK ? target_raw : {target_raw[31:2], 2'b00};
   end

   always_comb begin
      state_d      = state_q;
      pc_f_d       = pc_f_q;
      pc_ex_d      = pc_ex_q;
      hold_buf_d   = hold_buf_q;
      hold_valid_d = hold_valid_q;
      fault_d      = fault_q;
      if (hold) begin
         if (!hold_valid_q) begin
            hold_buf_d   = imem_rdata;
            hold_valid_d = 1'b1;
         end
      end else begin
         hold_valid_d = 1'b0;
         case (state_q)
            RUN: begin
               if (stall_FETCH) begin
                  if (misaligned) begin
                     state_d = FAULT;
                     fault_d = 1'b1;
                  end else begin
                     pc_f_d  = target;
                     pc_ex_d = pc_f_q;
                     state_d = SQUASH;
                  end
               end else begin
                  pc_ex_d = pc_f_q;
                  pc_f_d  = pc_f_q + 32'd4;
                  state_d = RUN;
               end
            end
            BOOT, SQUASH: begin
               pc_ex_d = pc_f_q;
               pc_f_d  = pc_f_q + 32'd4;
               state_d = RUN;
            end
            default: state_d = FAULT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= BOOT;
         pc_f_q       <= RESET_PC;
         pc_ex_q      <= RESET_PC;
         hold_buf_q   <= NOP;
         hold_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_f_q       <= pc_f_d;
         pc_ex_q      <= pc_ex_d;
         hold_buf_q   <= hold_buf_d;
         hold_valid_q <= hold_valid_d;
         fault_q      <= fault_d;
      end
   end

endmodule
